// File: rtl/bus_timer_if.sv
// Register-bus bundle for bus_timer: CPU-side select/strobe/address/data/lanes
// and combinational read-back data.
interface bus_timer_if;
    logic        busSel;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  Byte_Enable;
    logic [31:0] busRData;

    modport master (
        output busSel, busWe, busAddr, busWData, Byte_Enable,
        input  busRData
    );

    modport slave (
        input  busSel, busWe, busAddr, busWData, Byte_Enable,
        output busRData
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped prescaled up-counter with compare match, auto-reload/one-shot
// modes, W1C match flag and registered interrupt request.
module bus_timer (
    input  logic        clk,
    input  logic        reset,
    bus_timer_if.slave  bus,
    output logic        irq
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic        ie_reg, ie_next;
    logic        ar_reg, ar_next;
    logic [15:0] psc_reg, psc_next;
    logic [15:0] pcnt_reg, pcnt_next;
    logic [31:0] arr_reg, arr_next;
    logic [31:0] cnt_reg, cnt_next;
    logic        mf_reg, mf_next;
    logic        irq_reg;

    logic [2:0]  reg_idx;
    logic        wr_en;
    logic        wr_ctrl, wr_psc, wr_arr, wr_status;
    logic        ctrl_lane0;
    logic        clr;
    logic        w1c;
    logic        tick;
    logic        match;
    logic [31:0] lane_mask;
    logic        unused_addr_bits;

    assign reg_idx          = bus.busAddr[4:2];
    assign unused_addr_bits = ^{bus.busAddr[31:5], bus.busAddr[1:0]};
    assign wr_en            = bus.busSel && bus.busWe;
    assign wr_ctrl          = wr_en && (reg_idx == 3'd0);
    assign wr_psc           = wr_en && (reg_idx == 3'd1);
    assign wr_arr           = wr_en && (reg_idx == 3'd2);
    assign wr_status        = wr_en && (reg_idx == 3'd4);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_mask[8*gi +: 8] = {8{bus.Byte_Enable[gi]}};
        end
    endgenerate

    // All CTRL and STATUS fields live in byte lane 0.
    assign ctrl_lane0 = wr_ctrl && bus.Byte_Enable[0];
    assign clr        = ctrl_lane0 && bus.busWData[1];
    assign w1c        = wr_status && bus.Byte_Enable[0] && bus.busWData[0];

    assign tick  = (state_reg == RUN) && (pcnt_reg == psc_reg);
    assign match = tick && (cnt_reg == arr_reg);

    always_comb begin
        state_next = state_reg;
        ie_next    = ie_reg;
        ar_next    = ar_reg;
        psc_next   = psc_reg;
        pcnt_next  = pcnt_reg;
        arr_next   = arr_reg;
        cnt_next   = cnt_reg;

        if (state_reg == RUN) begin
            if (tick) begin
                pcnt_next = 16'd0;
                if (match) begin
                    cnt_next = 32'd0;
                    if (!ar_reg) begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + 32'd1;
                end
            end else begin
                pcnt_next = pcnt_reg + 16'd1;
            end
        end

        if (wr_psc) begin
            if (bus.Byte_Enable[0]) psc_next[7:0]  = bus.busWData[7:0];
            if (bus.Byte_Enable[1]) psc_next[15:8] = bus.busWData[15:8];
        end

        if (wr_arr) begin
            arr_next = (arr_reg & ~lane_mask) | (bus.busWData & lane_mask);
        end

        // A CTRL write decides EN outright, so it also overrides a one-shot stop.
        if (ctrl_lane0) begin
            state_next = bus.busWData[0] ? RUN : IDLE;
            ie_next    = bus.busWData[2];
            ar_next    = bus.busWData[3];
            if (bus.busWData[0] && (state_reg == IDLE)) begin
                pcnt_next = 16'd0;
            end
            if (clr) begin
                cnt_next  = 32'd0;
                pcnt_next = 16'd0;
            end
        end

        // Hardware set beats software clear; CLR suppresses the set.
        mf_next = (mf_reg && !w1c) || (match && !clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ie_reg    <= 1'b0;
            ar_reg    <= 1'b0;
            psc_reg   <= 16'd0;
            pcnt_reg  <= 16'd0;
            arr_reg   <= 32'd0;
            cnt_reg   <= 32'd0;
            mf_reg    <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ie_reg    <= ie_next;
            ar_reg    <= ar_next;
            psc_reg   <= psc_next;
            pcnt_reg  <= pcnt_next;
            arr_reg   <= arr_next;
            cnt_reg   <= cnt_next;
            mf_reg    <= mf_next;
            irq_reg   <= mf_reg && ie_reg;
        end
    end

    assign irq = irq_reg;

    always_comb begin
        bus.busRData = 32'd0;
        case (reg_idx)
            3'd0:    bus.busRData = {28'd0, ar_reg, ie_reg, 1'b0, (state_reg == RUN)};
            3'd1:    bus.busRData = {16'd0, psc_reg};
            3'd2:    bus.busRData = arr_reg;
            3'd3:    bus.busRData = cnt_reg;
            3'd4:    bus.busRData = {31'd0, mf_reg};
            default: bus.busRData = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: stimulus queues expected values, a monitor
// samples the DUT on each check strobe and compares against the queue head.
module tb_bus_timer;
    logic clk = 1'b0;
    logic reset;
    logic irq;

    bus_timer_if bus ();

    bus_timer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #20 clk = ~clk;

    typedef struct {
        bit          kind;   // 0: busRData, 1: irq
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   chk_strobe;

    always @(negedge chk_strobe) begin : monitor
        exp_t        e;
        logic [31:0] act;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL monitor: strobe with empty queue, got 0 entries required 1");
        end else begin
            e   = exp_q.pop_front();
            act = e.kind ? {31'd0, irq} : bus.busRData;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h required 0x%08h", e.name, act, e.exp);
            end else begin
                $display("ok   %s = 0x%08h", e.name, act);
            end
        end
    end

    task automatic sync(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe();
        #1 chk_strobe = 1'b1;
        #1 chk_strobe = 1'b0;
        #1;
    endtask

    task automatic chk_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        exp_t e;
        bus.busAddr = addr;
        e.kind = 1'b0;
        e.exp  = exp;
        e.name = name;
        exp_q.push_back(e);
        strobe();
    endtask

    task automatic chk_irq(input logic exp, input string name);
        exp_t e;
        e.kind = 1'b1;
        e.exp  = {31'd0, exp};
        e.name = name;
        exp_q.push_back(e);
        strobe();
    endtask

    task automatic wr_begin(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.busSel      = 1'b1;
        bus.busWe       = 1'b1;
        bus.busAddr     = addr;
        bus.busWData    = data;
        bus.Byte_Enable = be;
    endtask

    task automatic wr_end();
        @(posedge clk);
        #1;
        bus.busSel = 1'b0;
        bus.busWe  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        wr_begin(addr, data, be);
        wr_end();
    endtask

    initial begin
        reset           = 1'b1;
        bus.busSel      = 1'b0;
        bus.busWe       = 1'b0;
        bus.busAddr     = 32'd0;
        bus.busWData    = 32'd0;
        bus.Byte_Enable = 4'h0;
        sync(2);
        reset = 1'b0;

        // Reset state
        chk_rd(32'h00, 32'h0, "rst_ctrl");
        chk_rd(32'h04, 32'h0, "rst_psc");
        chk_rd(32'h08, 32'h0, "rst_arr");
        chk_rd(32'h0C, 32'h0, "rst_cnt");
        chk_rd(32'h10, 32'h0, "rst_status");
        chk_rd(32'h14, 32'h0, "rst_unmapped");
        chk_irq(1'b0, "rst_irq");

        // Byte lanes; read during the write cycle still shows the old value
        wr_begin(32'h08, 32'hAABBCCDD, 4'b0101);
        chk_rd(32'h08, 32'h0, "arr_before_write");
        wr_end();
        chk_rd(32'h08, 32'h00BB00DD, "arr_lanes");
        wr(32'h04, 32'hFFFF1234, 4'b0011);
        chk_rd(32'h04, 32'h00001234, "psc_lanes");
        wr(32'h14, 32'hFFFFFFFF, 4'hF);
        chk_rd(32'h14, 32'h0, "unmapped_14");
        chk_rd(32'hFFFF_FF08, 32'h00BB00DD, "arr_alias_high_bits");

        // busSel=0 blocks writes but reads still work
        bus.busSel      = 1'b0;
        bus.busWe       = 1'b1;
        bus.busAddr     = 32'h00;
        bus.busWData    = 32'h0000000F;
        bus.Byte_Enable = 4'hF;
        chk_rd(32'h08, 32'h00BB00DD, "nosel_read_arr");
        bus.busAddr = 32'h00;
        sync(1);
        bus.busWe = 1'b0;
        chk_rd(32'h00, 32'h0, "nosel_ctrl");
        sync(2);
        chk_rd(32'h0C, 32'h0, "nosel_cnt");

        // Periodic count: PSC=3, ARR=2, EN|IE|AR
        wr(32'h04, 32'd3, 4'hF);
        wr(32'h08, 32'd2, 4'hF);
        wr(32'h00, 32'hD, 4'hF);
        sync(3);  chk_rd(32'h0C, 32'd0, "per_cnt_e3");
        sync(1);  chk_rd(32'h0C, 32'd1, "per_cnt_e4");
        sync(4);  chk_rd(32'h0C, 32'd2, "per_cnt_e8");
                  chk_rd(32'h10, 32'd0, "per_mf_e8");
                  chk_irq(1'b0, "per_irq_e8");
        sync(3);  chk_rd(32'h0C, 32'd2, "per_cnt_e11");
                  chk_rd(32'h10, 32'd0, "per_mf_e11");
        sync(1);  chk_rd(32'h0C, 32'd0, "per_cnt_e12");
                  chk_rd(32'h10, 32'd1, "per_mf_e12");
                  chk_irq(1'b0, "per_irq_e12");
                  chk_rd(32'h00, 32'hD, "per_ctrl_e12");
        sync(1);  chk_irq(1'b1, "per_irq_e13");
        wr(32'h10, 32'd1, 4'hF);
                  chk_rd(32'h10, 32'd0, "w1c_mf");
                  chk_irq(1'b1, "w1c_irq_lag");
        sync(1);  chk_irq(1'b0, "w1c_irq_clear");

        // W1C on the match edge: set wins
        sync(8);
        wr(32'h10, 32'd1, 4'hF);
        chk_rd(32'h10, 32'd1, "coll_w1c_match_mf");
        chk_rd(32'h0C, 32'd0, "coll_w1c_match_cnt");
        wr(32'h10, 32'd1, 4'hF);
        chk_rd(32'h10, 32'd0, "mf_cleared_again");

        // CLR on the match tick: CNT=0, MF stays 0, pcnt restarts
        sync(10);
        wr(32'h00, 32'hF, 4'hF);
        chk_rd(32'h0C, 32'd0, "coll_clr_cnt");
        chk_rd(32'h10, 32'd0, "coll_clr_mf");
        chk_rd(32'h00, 32'hD, "coll_clr_ctrl");
        sync(3);  chk_rd(32'h0C, 32'd0, "clr_cnt_e39");
        sync(1);  chk_rd(32'h0C, 32'd1, "clr_cnt_e40");
        wr(32'h00, 32'h0, 4'hF);
        chk_rd(32'h00, 32'h0, "stop_ctrl");
        sync(10); chk_rd(32'h0C, 32'd1, "stop_cnt_hold");

        // One-shot: PSC=0, ARR=5, EN only
        wr(32'h04, 32'd0, 4'hF);
        wr(32'h08, 32'd5, 4'hF);
        wr(32'h00, 32'h2, 4'hF);
        chk_rd(32'h0C, 32'd0, "os_clr_cnt");
        wr(32'h00, 32'h1, 4'hF);
        sync(5);  chk_rd(32'h0C, 32'd5, "os_cnt_5");
                  chk_rd(32'h00, 32'h1, "os_ctrl_run");
        sync(1);  chk_rd(32'h0C, 32'd0, "os_cnt_wrap");
                  chk_rd(32'h10, 32'd1, "os_mf");
                  chk_rd(32'h00, 32'h0, "os_en_clear");
        sync(5);  chk_rd(32'h0C, 32'd0, "os_cnt_stays");
                  chk_irq(1'b0, "os_irq_ie0");

        // ARR=0 matches every tick; ARR rewrite mid-run
        wr(32'h10, 32'd1, 4'hF);
        wr(32'h08, 32'd0, 4'hF);
        wr(32'h00, 32'h9, 4'hF);
        sync(1);  chk_rd(32'h10, 32'd1, "arr0_mf");
                  chk_rd(32'h0C, 32'd0, "arr0_cnt");
        wr(32'h08, 32'd3, 4'hF);
        sync(2);  chk_rd(32'h0C, 32'd2, "arr_rewrite_cnt");

        // CLR on a non-match tick; MF unchanged
        wr(32'h00, 32'h6, 4'hF);
        chk_rd(32'h0C, 32'd0, "clr_tick_cnt");
        chk_rd(32'h10, 32'd1, "clr_tick_mf");
        wr(32'h08, 32'd100, 4'hF);
        wr(32'h00, 32'hD, 4'hF);
        sync(6);  chk_rd(32'h0C, 32'd6, "pre_rst_cnt6");
                  chk_irq(1'b1, "pre_rst_irq");
        sync(1);  chk_rd(32'h0C, 32'd7, "pre_rst_cnt7");

        // Reset mid-run with a same-cycle ARR write
        reset = 1'b1;
        wr_begin(32'h08, 32'd9, 4'hF);
        wr_end();
        reset = 1'b0;
        chk_rd(32'h00, 32'h0, "mrst_ctrl");
        chk_rd(32'h04, 32'h0, "mrst_psc");
        chk_rd(32'h08, 32'h0, "mrst_arr");
        chk_rd(32'h0C, 32'h0, "mrst_cnt");
        chk_rd(32'h10, 32'h0, "mrst_status");
        chk_irq(1'b0, "mrst_irq");
        sync(5);  chk_rd(32'h0C, 32'h0, "mrst_no_count");
                  chk_rd(32'h00, 32'h0, "mrst_ctrl_idle");
        wr(32'h08, 32'd10, 4'hF);
        wr(32'h00, 32'h1, 4'hF);
        sync(3);  chk_rd(32'h0C, 32'd3, "mrst_resume");

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d entries required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
